uart_rcv: RTL
=============

# uart_rcv

Serial receiver for the UART link: recovers 8N1 frames from the asynchronous `RX` line and presents each byte in parallel with a ready flag. It sits directly downstream of the UART transmitter on the far end of the link. It shares that transmitter's bit timing of 2604 clocks per bit, so the two interoperate. Framing errors and overruns are reported instead of silently dropped.

## Interface
- `BAUD_CYCLES`, 2604: clocks per bit; must be even and ≥ 16.
- `CNT_W`, `$clog2(BAUD_CYCLES)`: baud counter width (12 at default).

- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `RX`  in  1  serial line, idle high, asynchronous to `clk`.
- `clr_rdy`  in  1  consumer acknowledge; clears `rdy`, `frm_err`, `ovr`.
- `rx_data`  out  8  last good byte received, LSB first on the wire.
- `rdy`  out  1  new byte valid in `rx_data`.
- `frm_err`  out  1  last frame had stop bit = 0.
- `ovr`  out  1  a byte completed while `rdy` was still set.

## Operation
- **Input synchronizer**
  - `RX` passes through 2 flops before any use; both reset to 1.
  - The FSM sees only the synced bit `rx_s`.
- **States**
  - `IDLE`
    - Stays here while `rx_s` = 1.
    - On `rx_s` = 0: loads the baud counter with `BAUD_CYCLES/2`, clears `bit_cnt`, clears `rdy` and `frm_err` (not `ovr`), then goes to `START`.
  - `START`
    - Counts down to 0 (mid start bit), then samples `rx_s`.
    - Sample = 1: glitch; return to `IDLE`, no flags change.
    - Sample = 0: reload `BAUD_CYCLES`, go to `DATA`.
  - `DATA`
    - At each counter expiry, shift `rx_s` into the MSB of a 9-bit shift register (`shreg >> 1`), increment `bit_cnt`, and reload `BAUD_CYCLES`.
    - After the 9th sample (8 data + stop), evaluate the stop bit in `shreg[8]`:
      - stop = 1: `rx_data <= shreg[7:0]`; `rdy <= 1`; if `rdy` was already 1, `ovr <= 1`.
      - stop = 0: `frm_err <= 1`; `rx_data` unchanged; `rdy` stays 0.
    - Either way, go to `IDLE` at mid-stop-bit. This allows back-to-back frames with no gap.
- **Counter**
  - Counts down from its load value; expiry = 0.
  - Width `CNT_W`, no wrap: always reloaded on expiry.
- **`bit_cnt`**: 4 bits, range 0..9, reset 0.
- **`clr_rdy`**
  - Clears `rdy`, `frm_err` and `ovr` the next cycle.
  - If `clr_rdy` coincides with a set event, the set wins.
- **`RX` behaviour**
  - Held low (break): gives a `frm_err` frame, then the FSM re-enters `START` immediately and repeats every frame time. `rdy` is never asserted.
  - Held high: FSM stays in `IDLE` indefinitely.
- **Reset mid-frame**: all state returns to reset values asynchronously. The partial frame is discarded. A frame already in flight on the line is picked up at the next falling edge, which may produce a `frm_err`.

## Timing
- **Reset values**: `rx_data` = 8'h00, `rdy` = 0, `frm_err` = 0, `ovr` = 0, state `IDLE`, sync flops = 1.
- **Detection**: `RX` falling edge to `START` entry takes 3 clocks (2 sync + 1 state).
- **Sampling**
  - Start-bit sample at `BAUD_CYCLES/2` after `START` entry.
  - Data bit k sampled `BAUD_CYCLES/2` + (k+1)·`BAUD_CYCLES` after `START` entry.
  - Stop bit sampled at `BAUD_CYCLES/2` + 9·`BAUD_CYCLES`.
- **Latency**: `rdy`/`frm_err` assert 1 clock after the stop sample. At default this is 24,742 ±1 clocks after the `RX` falling edge.
- **Output registers**: `rdy`, `frm_err`, `ovr` and `rx_data` are registered; no combinational path from `RX`.
- **Tolerance**: sampling at mid-bit tolerates up to ±4% sender baud mismatch over 10 bits.

## Test plan
- **Single frame**: after reset, bench BFM sends 0xA5 at 2604 clk/bit → `rdy` rises 24,742 ±1 clocks after the start edge, `rx_data` = 0xA5, `frm_err` = 0, `ovr` = 0.
- **Back-to-back**: send 0x00, 0xFF, 0x5A with no idle gap, pulsing `clr_rdy` after each → three `rdy` pulses with matching data, no `frm_err`.
- **Glitch rejection**: drive `RX` low for 1000 clocks then high → no `rdy`, no `frm_err`, FSM back in `IDLE`. A subsequent 0x3C is received correctly.
- **Framing error**: send 0x81 with stop bit = 0 → `frm_err` = 1, `rdy` = 0, `rx_data` keeps the previous value. `clr_rdy` → `frm_err` = 0 next cycle.
- **Overrun**: send 0x11 then 0x22 without `clr_rdy` → `rx_data` = 0x22, `rdy` = 1, `ovr` = 1. Send `clr_rdy` together with a third frame's stop-sample cycle → `rdy` remains 1.
- **Reset mid-frame**: assert `rst_n` low during data bit 4 of 0xC3 → all outputs go to reset values immediately. After release, a clean 0x96 frame → `rx_data` = 0x96.

Source files
------------

// File: rtl/uart_rcv.sv
// 8N1 serial receiver, mid-bit sampling; rdy/frm_err rise one clock after the stop-bit sample.
// No backpressure: an unacknowledged byte is overwritten and flagged through ovr.
module uart_rcv #(
    parameter int BAUD_CYCLES = 2604,
    parameter int CNT_W       = $clog2(BAUD_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr
);
    typedef enum logic [1:0] {IDLE, START, DATA} state_t;

    // Expiry is the cycle the counter reads zero, so each load is one short of the interval.
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BAUD_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BAUD_CYCLES - 1);

    state_t           state_q, state_d;
    logic             rx_m, rx_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       sh_q, sh_d;
    logic             frame_start, stop_eval, good, bad;
    // rdy drops at every frame start, so overrun is tracked by whether the last byte was acknowledged.
    logic             pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        frame_start = 1'b0;
        stop_eval   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d       = HALF_LD;
                    bit_d       = 4'd0;
                    frame_start = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = FULL_LD;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    sh_d  = {rx_s, sh_q[8:1]};
                    bit_d = bit_q + 4'd1;
                    cnt_d = FULL_LD;
                    if (bit_q == 4'd8) begin
                        stop_eval = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign good = stop_eval & sh_d[8];
    assign bad  = stop_eval & ~sh_d[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            sh_q    <= 9'd0;
            rx_data <= 8'h00;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            ovr     <= 1'b0;
            pend    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            if (good) rx_data <= sh_d[7:0];

            if (good)                        rdy <= 1'b1;
            else if (frame_start || clr_rdy) rdy <= 1'b0;

            if (bad)                         frm_err <= 1'b1;
            else if (frame_start || clr_rdy) frm_err <= 1'b0;

            if (good && pend)  ovr <= 1'b1;
            else if (clr_rdy)  ovr <= 1'b0;

            if (good)          pend <= 1'b1;
            else if (clr_rdy)  pend <= 1'b0;
        end
    end
endmodule
